// File: rtl/mips_pkg.sv
// Shared MIPS encodings and fetch-unit types for the instruction fetch path.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    typedef enum logic {FETCH, EXEC} fetchState_t;

    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface ifu_npc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifu_npc_calc.sv
// Combinational next-PC selection: J/JAL, JR/JALR, conditional branches, sequential.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        branch,
    input  logic        jump,
    output logic [31:0] nextPc,
    output logic [31:0] pcPlus4,
    output logic        misalignRaw
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rtField;
    logic       isJump;
    logic       isJr;
    logic       cond;
    logic       rsZero;

    assign op      = ins[31:26];
    assign funct   = ins[5:0];
    assign rtField = ins[20:16];
    assign pcPlus4 = pc + 32'd4;
    assign rsZero  = (rsData == 32'h0);
    assign isJump  = jump && ((op == OP_J) || (op == OP_JAL));
    // JR/JALR are decoded here; the decoder never raises jump for them.
    assign isJr    = (op == OP_R) && ((funct == FN_JR) || (funct == FN_JALR));
    assign misalignRaw = isJr && (rsData[1:0] != 2'b00);

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_BEQ:    cond = (rsData == rtData);
            OP_BNE:    cond = (rsData != rtData);
            OP_BLEZ:   cond = rsData[31] || rsZero;
            OP_BGTZ:   cond = !rsData[31] && !rsZero;
            OP_REGIMM: begin
                if (rtField == RT_BLTZ)      cond = rsData[31];
                else if (rtField == RT_BGEZ) cond = !rsData[31];
            end
            default:   cond = 1'b0;
        endcase
    end

    always_comb begin
        nextPc = pcPlus4;
        if (isJump)
            nextPc = {pcPlus4[31:28], ins[25:0], 2'b00};
        else if (isJr)
            nextPc = {rsData[31:2], 2'b00};
        else if (branch && cond)
            nextPc = pcPlus4 + branchOffset(ins[15:0]);
    end

endmodule

// File: rtl/ifu_npc.sv
// Fetch unit: holds PC, fetches over req/ack, presents ins for one or more
// EXEC cycles, then commits the next PC.
module ifu_npc
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    ifu_npc_if.master        imem,
    output logic [31:0]      ins,
    output logic             ins_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             branch,
    input  logic             jump,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             hold,
    output logic             misalign
);

    fetchState_t state;
    logic [31:0] nextPc;
    logic        misalignRaw;

    npc_calc uCalc (
        .ins         (ins),
        .pc          (pc),
        .rsData      (rs_data),
        .rtData      (rt_data),
        .branch      (branch),
        .jump        (jump),
        .nextPc      (nextPc),
        .pcPlus4     (pc_plus4),
        .misalignRaw (misalignRaw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ins   <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        ins   <= imem.imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        pc    <= nextPc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Request is gated by rst so a fetch is dropped the instant reset asserts.
    assign imem.imem_req  = (state == FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign ins_valid      = (state == EXEC);
    assign misalign       = (state == EXEC) && !hold && misalignRaw;

endmodule

// File: tb/tb_ifu_npc.sv
// Directed bench for ifu_npc: handshake timing, hold, next-PC rules, reset mid-fetch.
module tb_ifu_npc;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        jump;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hold;
    logic        misalign;
    int          checks;
    int          errors;

    ifu_npc_if imemBus ();

    ifu_npc #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imemBus.master),
        .ins       (ins),
        .ins_valid (ins_valid),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .branch    (branch),
        .jump      (jump),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hold      (hold),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ":req"},   32'(imemBus.imem_req), 32'd0);
        chk({tag, ":valid"}, 32'(ins_valid), 32'd0);
        chk({tag, ":ins"},   ins, 32'h0);
        chk({tag, ":pc"},    pc, 32'h0000_3000);
        chk({tag, ":mis"},   32'(misalign), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Fetch one word at expPc after waitCyc idle cycles, hold EXEC holdCyc
    // cycles (with a stray ack), then commit with the given decoder inputs.
    task automatic runInstr(input string tag, input logic [31:0] expPc, input logic [31:0] word,
                            input int waitCyc, input int holdCyc, input logic br, input logic jmp,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic expMis, input logic [31:0] expNext);
        chk({tag, ":req"},  32'(imemBus.imem_req), 32'd1);
        chk({tag, ":addr"}, imemBus.imem_addr, expPc);
        repeat (waitCyc) begin
            @(posedge clk);
            #1;
            chk({tag, ":waitAddr"}, imemBus.imem_addr, expPc);
            chk({tag, ":waitValid"}, 32'(ins_valid), 32'd0);
        end
        imemBus.imem_ack   = 1'b1;
        imemBus.imem_rdata = word;
        @(posedge clk);
        #1;
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = 32'hDEAD_BEEF;
        chk({tag, ":valid"}, 32'(ins_valid), 32'd1);
        chk({tag, ":ins"},   ins, word);
        chk({tag, ":pc"},    pc, expPc);
        chk({tag, ":pc4"},   pc_plus4, expPc + 32'd4);
        chk({tag, ":execReq"}, 32'(imemBus.imem_req), 32'd0);
        branch  = br;
        jump    = jmp;
        rs_data = rs;
        rt_data = rt;
        repeat (holdCyc) begin
            hold = 1'b1;
            imemBus.imem_ack = 1'b1;
            @(posedge clk);
            #1;
            imemBus.imem_ack = 1'b0;
            chk({tag, ":holdValid"}, 32'(ins_valid), 32'd1);
            chk({tag, ":holdPc"},    pc, expPc);
            chk({tag, ":holdIns"},   ins, word);
        end
        hold = 1'b0;
        #1;
        chk({tag, ":mis"}, 32'(misalign), 32'(expMis));
        @(posedge clk);
        #1;
        branch = 1'b0;
        jump   = 1'b0;
        chk({tag, ":misAfter"}, 32'(misalign), 32'd0);
        chk({tag, ":nextValid"}, 32'(ins_valid), 32'd0);
        chk({tag, ":next"}, imemBus.imem_addr, expNext);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        branch = 1'b0;
        jump = 1'b0;
        hold = 1'b0;
        rs_data = 32'h0;
        rt_data = 32'h0;
        imemBus.imem_ack = 1'b0;
        imemBus.imem_rdata = 32'h0;

        doReset("reset0");
        runInstr("first",  32'h3000, 32'h2408_0005, 1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3004);
        runInstr("seq4",   32'h3004, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3008);
        runInstr("seq8",   32'h3008, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h300C);
        runInstr("seqC",   32'h300C, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3010);
        runInstr("beqT",   32'h3010, 32'h1022_FFFC, 0, 0, 1'b1, 1'b0, 32'd7, 32'd7, 1'b0, 32'h3004);
        runInstr("walk4",  32'h3004, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3008);
        runInstr("walk8",  32'h3008, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h300C);
        runInstr("walkC",  32'h300C, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3010);
        runInstr("beqN",   32'h3010, 32'h1022_FFFC, 0, 0, 1'b1, 1'b0, 32'd7, 32'd8, 1'b0, 32'h3014);
        runInstr("bgezT",  32'h3014, 32'h0421_0004, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3028);
        runInstr("bgezN",  32'h3028, 32'h0421_0004, 0, 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h302C);
        runInstr("sbBr",   32'h302C, 32'hA000_0000, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3030);
        runInstr("jal",    32'h3030, 32'h0C00_0C10, 0, 0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h3040);
        runInstr("jrMis",  32'h3040, 32'h0020_0008, 0, 0, 1'b0, 1'b0, 32'h0000_3052, 32'h0, 1'b1, 32'h3050);
        runInstr("bneJmp", 32'h3050, 32'h1422_0002, 0, 0, 1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 32'h305C);
        runInstr("blezSelf", 32'h305C, 32'h1820_FFFF, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h305C);
        runInstr("bgtzN",  32'h305C, 32'h1C20_0004, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3060);
        runInstr("jalr",   32'h3060, 32'h0020_0009, 0, 0, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 32'h3000);
        runInstr("regimmX", 32'h3000, 32'h0422_0004, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h3004);
        runInstr("jNoStb", 32'h3004, 32'h0800_0C10, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3008);
        runInstr("bgtzT",  32'h3008, 32'h1C20_0004, 0, 0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'h301C);
        runInstr("bltzT",  32'h301C, 32'h0420_0002, 0, 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h3028);

        doReset("reset1");
        runInstr("holdWait", 32'h3000, 32'h2408_0005, 3, 2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3004);
        runInstr("jal2",   32'h3004, 32'h0C00_0C10, 0, 0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h3040);

        imemBus.imem_ack   = 1'b1;
        imemBus.imem_rdata = 32'h1234_5678;
        rst = 1'b1;
        #1;
        chk("midRst:req",   32'(imemBus.imem_req), 32'd0);
        chk("midRst:pc",    pc, 32'h0000_3000);
        chk("midRst:ins",   ins, 32'h0);
        chk("midRst:valid", 32'(ins_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("midRst:lateIns", ins, 32'h0);
        chk("midRst:lateValid", 32'(ins_valid), 32'd0);
        imemBus.imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        runInstr("afterRst", 32'h3000, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
